// File: rtl/proc_io_pkg.sv
// proc_io_pkg
//   Shared constants and sizing helpers for the processor I/O port blocks.
//   NUBITS_DEFAULT : default sample word width (processor data bus width)
//   clog2()        : ceiling log2, usable in constant expressions
//   count_width()  : width of a fill-level counter able to hold 0..depth
package proc_io_pkg;

    localparam int NUBITS_DEFAULT = 32;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int count_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
//   Simple dual-port storage: synchronous write, asynchronous read.
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
//   Contents are not reset.
module fifo_ram
    import proc_io_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEFAULT,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [clog2(DEPTH)-1:0]  waddr,
    input  logic [NUBITS-1:0]        wdata,
    input  logic [clog2(DEPTH)-1:0]  raddr,
    output logic [NUBITS-1:0]        rdata
);

    logic [NUBITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/proc_in_fifo.sv
// proc_in_fifo
//   Input FIFO between an external sample source and the processor data
//   input. Show-ahead: the head word is visible on io_in before it is read.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   s_data   : signed sample from the source
//   s_valid  : s_data valid this cycle
//   s_ready  : FIFO accepts a sample this cycle
//   io_in    : signed head-of-FIFO word (0 when empty)
//   req_in   : processor read strobe, consumes the head word
//   itr      : interrupt request, high while fill level >= THRESH
//   count    : current fill level
//   udf      : sticky underflow flag (read while empty), cleared by rst
//   drop_cnt : saturating count of samples discarded while full
//              (present only with PROC_IN_FIFO_DROP_EN defined)
//   Macro PROC_IN_FIFO_DROP_EN: s_ready tied high, pushes into a full FIFO
//   are dropped and counted instead of being back-pressured.
module proc_in_fifo
    import proc_io_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEFAULT,
    parameter int DEPTH  = 16,
    parameter int THRESH = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [NUBITS-1:0]       s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic signed [NUBITS-1:0]       io_in,
    input  logic                           req_in,
    output logic                           itr,
    output logic [count_width(DEPTH)-1:0]  count,
    output logic                           udf
`ifdef PROC_IN_FIFO_DROP_EN
    ,
    output logic [15:0]                    drop_cnt
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              udf_q, udf_d;
    logic              full, empty, push, pop;
    logic [NUBITS-1:0] rd_data;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        // A full FIFO never accepts a push, even with a pop in the same
        // cycle: in back-pressure mode s_ready is already low, in drop mode
        // the sample is discarded.
        push     = s_valid && !full;
        pop      = req_in && !empty;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        udf_d    = udf_q || (req_in && empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .NUBITS (NUBITS),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (s_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

`ifdef PROC_IN_FIFO_DROP_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (s_valid && full && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign s_ready  = 1'b1;
`else
    assign s_ready  = !full;
`endif

    assign io_in = empty ? '0 : rd_data;
    assign itr   = (count_q >= CW'(THRESH));
    assign count = count_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_proc_in_fifo.sv
module tb_proc_in_fifo;

`ifdef PROC_IN_FIFO_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic signed [31:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              req_in = 1'b0;
    logic              s_ready, itr, udf;
    logic signed [31:0] io_in;
    logic [4:0]        count;

    logic signed [31:0] s_data4 = '0;
    logic              s_valid4 = 1'b0;
    logic              req_in4 = 1'b0;
    logic              s_ready4, itr4, udf4;
    logic signed [31:0] io_in4;
    logic [4:0]        count4;

`ifdef PROC_IN_FIFO_DROP_EN
    logic [15:0] drop_cnt, drop_cnt4;
`endif

    proc_in_fifo #(.NUBITS(32), .DEPTH(16), .THRESH(1)) u_dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .io_in(io_in), .req_in(req_in), .itr(itr),
        .count(count), .udf(udf)
`ifdef PROC_IN_FIFO_DROP_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    proc_in_fifo #(.NUBITS(32), .DEPTH(16), .THRESH(4)) u_dut4 (
        .clk(clk), .rst(rst), .s_data(s_data4), .s_valid(s_valid4),
        .s_ready(s_ready4), .io_in(io_in4), .req_in(req_in4), .itr(itr4),
        .count(count4), .udf(udf4)
`ifdef PROC_IN_FIFO_DROP_EN
        , .drop_cnt(drop_cnt4)
`endif
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic               rst;
        logic               sv;
        logic signed [31:0] sd;
        logic               req;
        int                 cnt;
        int                 io;
        logic               rdy;
        logic               itr;
        logic               udf;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    function automatic int wval(input int i);
        return i * 37 - 700;
    endfunction

    initial begin
        // inputs applied before the edge; expectations hold after it
        tbl[0]  = '{1'b1, 1'b0,  0, 1'b0, 0,  0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1,  5, 1'b0, 1,  5, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, -7, 1'b0, 2,  5, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1,  9, 1'b0, 3,  5, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0,  0, 1'b1, 2, -7, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0,  0, 1'b1, 1,  9, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0,  0, 1'b1, 0,  0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 42, 1'b1, 1, 42, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0,  0, 1'b0, 1, 42, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0,  0, 1'b1, 0,  0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 77, 1'b1, 0,  0, 1'b1, 1'b0, 1'b0};

        tick();
        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; s_valid = tbl[i].sv; s_data = tbl[i].sd; req_in = tbl[i].req;
            tick();
            chk($sformatf("vec%0d.count", i), count, tbl[i].cnt);
            chk($sformatf("vec%0d.io_in", i), io_in, tbl[i].io);
            chk($sformatf("vec%0d.s_ready", i), s_ready, tbl[i].rdy);
            chk($sformatf("vec%0d.itr", i), itr, tbl[i].itr);
            chk($sformatf("vec%0d.udf", i), udf, tbl[i].udf);
        end
        rst = 1'b0; s_valid = 1'b0; req_in = 1'b0; s_data = '0;

        // fill to full, then read with a simultaneous push that must be refused
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_data = i;
            tick();
            chk($sformatf("fill%0d.count", i), count, i + 1);
        end
        s_valid = 1'b0;
        chk("full.s_ready", s_ready, DROP ? 1 : 0);
        chk("full.count", count, 16);
        chk("full.head", io_in, 0);
        s_valid = 1'b1; s_data = 100; req_in = 1'b1;
        chk("full.read_val", io_in, 0);
        tick();
        s_valid = 1'b0; req_in = 1'b0;
        chk("after_full.count", count, 15);
        chk("after_full.s_ready", s_ready, 1);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain%0d.io_in", i), io_in, i);
            req_in = 1'b1; tick(); req_in = 1'b0;
        end
        chk("drain.count", count, 0);
        chk("drain.io_in", io_in, 0);

        // continuous push+pop stream across pointer wrap
        rst = 1'b1; tick(); rst = 1'b0;
        s_valid = 1'b1; s_data = wval(0);
        tick();
        chk("stream.first_count", count, 1);
        for (int i = 1; i < 40; i++) begin
            s_data = wval(i); req_in = 1'b1;
            chk($sformatf("stream%0d.io_in", i - 1), io_in, wval(i - 1));
            tick();
            chk($sformatf("stream%0d.count", i), count, 1);
        end
        s_valid = 1'b0;
        chk("stream39.io_in", io_in, wval(39));
        tick(); req_in = 1'b0;
        chk("stream.end_count", count, 0);
        chk("stream.udf", udf, 0);

        // reset mid-stream with udf set and push/pop active
        rst = 1'b1; tick(); rst = 1'b0;
        req_in = 1'b1; tick(); req_in = 1'b0;
        chk("midrst.udf_pre", udf, 1);
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1; s_data = 300 + i; tick();
        end
        chk("midrst.count_pre", count, 7);
        chk("midrst.itr_pre", itr, 1);
        rst = 1'b1; s_valid = 1'b1; s_data = 555; req_in = 1'b1;
        tick();
        rst = 1'b0; s_valid = 1'b0; req_in = 1'b0;
        chk("midrst.count", count, 0);
        chk("midrst.udf", udf, 0);
        chk("midrst.s_ready", s_ready, 1);
        chk("midrst.io_in", io_in, 0);
        chk("midrst.itr", itr, 0);

        // THRESH = 4 instance
        chk("th4.itr_reset", itr4, 0);
        for (int i = 0; i < 3; i++) begin
            s_valid4 = 1'b1; s_data4 = 10 + i; tick();
            chk($sformatf("th4.push%0d.itr", i + 1), itr4, 0);
        end
        s_data4 = 13; tick(); s_valid4 = 1'b0;
        chk("th4.push4.itr", itr4, 1);
        chk("th4.push4.count", count4, 4);
        req_in4 = 1'b1; tick(); req_in4 = 1'b0;
        chk("th4.pop.itr", itr4, 0);
        chk("th4.pop.io_in", io_in4, 11);

`ifdef PROC_IN_FIFO_DROP_EN
        rst = 1'b1; tick(); rst = 1'b0;
        chk("drop.reset", drop_cnt, 0);
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_data = i; tick();
        end
        for (int i = 0; i < 3; i++) begin
            s_data = 200 + i; tick();
        end
        s_valid = 1'b0;
        chk("drop.cnt", drop_cnt, 3);
        chk("drop.count", count, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drop.drain%0d", i), io_in, i);
            req_in = 1'b1; tick(); req_in = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
